// File: rtl/kpg_pkg.sv
// Shared KPG carry-status codes and the single-lane combine function.
// Included by kpg_op and kpg_cmp.
package kpg_pkg;

    localparam logic [1:0] KPG_KILL = 2'b00;
    localparam logic [1:0] KPG_PROP = 2'b01;
    localparam logic [1:0] KPG_GEN  = 2'b11;
    localparam logic [1:0] KPG_RSVD = 2'b10;

    // K or G at position i dominates; P (and reserved) passes i-1 through.
    function automatic logic [1:0] kpg_combine(
        input logic [1:0] xi,
        input logic [1:0] xi1
    );
        logic pass;
        pass = (xi == KPG_PROP) || (xi == KPG_RSVD);
        return pass ? xi1 : xi;
    endfunction

endpackage

// File: rtl/kpg_op.sv
// Combinational single-lane KPG combine operator.
// The illegal-code flag exists only when KPG_CMP_CHECK_EN is defined.
module kpg_op
    import kpg_pkg::*;
(
    input  logic [1:0] xi,
    input  logic [1:0] xi1,
`ifdef KPG_CMP_CHECK_EN
    output logic       ill,
`endif
    output logic [1:0] res
);

    assign res = kpg_combine(xi, xi1);

`ifdef KPG_CMP_CHECK_EN
    assign ill = (xi == KPG_RSVD) || (xi1 == KPG_RSVD);
`endif

endmodule

// File: rtl/kpg_cmp.sv
// Registered parallel KPG combine stage, LANES independent lanes.
// Optional reserved-code checker enabled by KPG_CMP_CHECK_EN (adds err port).
module kpg_cmp
    import kpg_pkg::*;
#(
    parameter int LANES = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [2*LANES-1:0] xi,
    input  logic [2*LANES-1:0] xi1,
    output logic [2*LANES-1:0] out,
    output logic               out_valid
`ifdef KPG_CMP_CHECK_EN
    ,
    output logic               err
`endif
);

    logic [2*LANES-1:0] res;
`ifdef KPG_CMP_CHECK_EN
    logic [LANES-1:0]   ill;
`endif

    for (genvar n = 0; n < LANES; n++) begin : g_lane
        kpg_op u_op (
            .xi  (xi[2*n +: 2]),
            .xi1 (xi1[2*n +: 2]),
`ifdef KPG_CMP_CHECK_EN
            .ill (ill[n]),
`endif
            .res (res[2*n +: 2])
        );
    end

    // out holds across invalid cycles; only the valid flag drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= {LANES{KPG_KILL}};
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out <= res;
            end
        end
    end

`ifdef KPG_CMP_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else begin
            err <= in_valid && (|ill);
        end
    end
`endif

endmodule

// File: tb/tb_kpg_cmp.sv
// Randomized self-checking bench for kpg_cmp against a truth-table model.
// Build with +define+KPG_CMP_CHECK_EN to also exercise the err flag.
module tb_kpg_cmp;

    localparam int LANES = 8;
    localparam int W = 2 * LANES;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] xi = '0;
    logic [W-1:0] xi1 = '0;
    logic [W-1:0] out;
    logic         out_valid;
`ifdef KPG_CMP_CHECK_EN
    logic         err;
`endif

    int checks = 0;
    int failures = 0;

    logic [W-1:0] eo = '0;
    logic         ev = 1'b0;
    logic         ee = 1'b0;

    always #5 clk = ~clk;

    kpg_cmp #(.LANES(LANES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .xi        (xi),
        .xi1       (xi1),
        .out       (out),
        .out_valid (out_valid)
`ifdef KPG_CMP_CHECK_EN
        ,
        .err       (err)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Truth table: 00,x->00; 11,x->11; 01,y->y; 10,y->y.
    function automatic logic [W-1:0] ref_out(input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [W-1:0] r;
        int u;
        r = '0;
        for (int n = 0; n < LANES; n++) begin
            u = int'(a[2*n +: 2]);
            case (u)
                0:       r[2*n +: 2] = 2'd0;
                3:       r[2*n +: 2] = 2'd3;
                default: r[2*n +: 2] = b[2*n +: 2];
            endcase
        end
        return r;
    endfunction

    function automatic logic has_rsvd(input logic [W-1:0] a,
                                      input logic [W-1:0] b);
        for (int n = 0; n < LANES; n++) begin
            if (a[2*n +: 2] == 2'd2 || b[2*n +: 2] == 2'd2) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".out"}, 32'(out), 32'(eo));
        chk({tag, ".vld"}, 32'(out_valid), 32'(ev));
`ifdef KPG_CMP_CHECK_EN
        chk({tag, ".err"}, 32'(err), 32'(ee));
`endif
    endtask

    task automatic step(input logic iv, input logic [W-1:0] a,
                        input logic [W-1:0] b, input string tag);
        @(negedge clk);
        in_valid = iv;
        xi = a;
        xi1 = b;
        @(posedge clk);
        if (!rst_n) begin
            eo = '0;
            ev = 1'b0;
            ee = 1'b0;
        end else begin
            ev = iv;
            ee = iv && has_rsvd(a, b);
            if (iv) eo = ref_out(a, b);
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;

        // Reset held with valid all-GEN inputs.
        #2;
        check_all("rst_init");
        for (int i = 0; i < 3; i++) step(1'b1, {LANES{2'b11}}, '0, "rst_hold");
        @(negedge clk);
        rst_n = 1'b1;

        // Exhaustive lane 0, random upper lanes.
        for (int p = 0; p < 16; p++) begin
            a = W'($urandom);
            b = W'($urandom);
            a[1:0] = 2'(p >> 2);
            b[1:0] = 2'(p & 3);
            step(1'b1, a, b, "lane0");
            chk("lane0.res", 32'(out[1:0]), 32'(eo[1:0]));
        end
        step(1'b1, 16'h0001, 16'h0003, "ex_p_g");
        chk("ex_p_g.l0", 32'(out[1:0]), 32'd3);
        step(1'b1, 16'h0000, 16'h0003, "ex_k_g");
        chk("ex_k_g.l0", 32'(out[1:0]), 32'd0);
        step(1'b1, 16'h0003, 16'h0000, "ex_g_k");
        chk("ex_g_k.l0", 32'(out[1:0]), 32'd3);

        // Lane independence.
        step(1'b1, 16'h5555, 16'hC30C, "indep");
        chk("indep.const", 32'(out), 32'h0000C30C);

        // Hold.
        step(1'b1, 16'hFFFF, 16'h0000, "hold_set");
        step(1'b0, 16'h0000, 16'h1234, "hold");
        chk("hold.const", 32'(out), 32'h0000FFFF);

        // Mid-stream async reset between edges.
        step(1'b1, 16'h5555, 16'hABCD, "pre_rst");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        eo = '0;
        ev = 1'b0;
        ee = 1'b0;
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 16'h5555, 16'h3C3C, "post_rst");

`ifdef KPG_CMP_CHECK_EN
        a = 16'h5555;
        a[7:6] = 2'b10;
        b = 16'hFFFF;
        b[7:6] = 2'b00;
        step(1'b1, a, b, "chk_rsvd");
        chk("chk_rsvd.err1", 32'(err), 32'd1);
        chk("chk_rsvd.l3", 32'(out[7:6]), 32'd0);
        step(1'b1, 16'h5555, 16'hFFFF, "chk_ok");
        chk("chk_ok.err0", 32'(err), 32'd0);
`endif

        // Random traffic, including reserved codes and idle cycles.
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 3) != 0), W'($urandom), W'($urandom),
                 "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
